// File: rtl/regfile_wport_arbiter_pkg.sv
// Shared widths and limits for the register-file write-port arbiter.
package regfile_wport_arbiter_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned REG_DATA_W = 32;
  localparam int unsigned MAX_NREQ   = 4;

  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

endpackage

// File: rtl/regfile_wport_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: the first valid bit at or after ptr wins.
module regfile_wport_arbiter_rr_pick
  import regfile_wport_arbiter_pkg::*;
#(
  parameter int unsigned NREQ = 2,
  parameter int unsigned PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] valid,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [PW-1:0]   gidx
);

  logic [PW:0]   sum;
  logic [PW-1:0] idx;
  logic          found;

  // Walk offsets 0..NREQ-1 from ptr, wrapping at NREQ (which need not be a power of two).
  always_comb begin
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      sum = {1'b0, ptr} + (PW+1)'(k);
      if (sum >= (PW+1)'(NREQ)) begin
        sum = sum - (PW+1)'(NREQ);
      end
      idx = sum[PW-1:0];
      if (!found && valid[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        gidx       = idx;
      end
    end
  end

endmodule

// File: rtl/regfile_wport_arbiter.sv
// Round-robin sharing of the register-file write port among NREQ writeback sources.
// Optional macro RF_WB_BYPASS_EN adds a same-cycle bypass view of the committing write.
module regfile_wport_arbiter
  import regfile_wport_arbiter_pkg::*;
#(
  parameter int unsigned NREQ = 2,
  parameter int unsigned AW   = REG_ADDR_W,
  parameter int unsigned DW   = REG_DATA_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [AW*NREQ-1:0] req_addr,
  input  logic [DW*NREQ-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  input  logic               rf_hold,
  output logic               rf_wen,
  output logic [AW-1:0]      rf_waddr,
  output logic [DW-1:0]      rf_wdata,
  output logic               busy
`ifdef RF_WB_BYPASS_EN
  ,
  input  logic [AW-1:0]      byp_addr,
  output logic               byp_hit,
  output logic [DW-1:0]      byp_data
`endif
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]   rr_ptr;
  logic [NREQ-1:0] pick_grant;
  logic [PW-1:0]   pick_idx;
  logic [NREQ-1:0] fire;
  logic            xfer;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_data;

  regfile_wport_arbiter_rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_pick (
    .valid (req_valid),
    .ptr   (rr_ptr),
    .grant (pick_grant),
    .gidx  (pick_idx)
  );

  assign req_ready = (reset || rf_hold) ? '0 : pick_grant;
  assign fire      = req_valid & req_ready;
  assign xfer      = |fire;
  assign busy      = (|req_valid) && !xfer;

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (fire[i]) begin
        sel_addr = req_addr[AW*i +: AW];
        sel_data = req_data[DW*i +: DW];
      end
    end
  end

  // Writes to $0 still complete the handshake and update addr/data; only the enable is suppressed.
  always_ff @(posedge clk) begin
    if (reset) begin
      rf_wen   <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      rr_ptr   <= '0;
    end else if (xfer) begin
      rf_wen   <= (sel_addr != AW'(ZERO_REG));
      rf_waddr <= sel_addr;
      rf_wdata <= sel_data;
      rr_ptr   <= (pick_idx == PW'(NREQ-1)) ? '0 : pick_idx + PW'(1);
    end else begin
      rf_wen   <= 1'b0;
    end
  end

`ifdef RF_WB_BYPASS_EN
  assign byp_hit  = rf_wen && (rf_waddr == byp_addr) && (byp_addr != AW'(ZERO_REG));
  assign byp_data = rf_wdata;
`endif

endmodule
